spi_slave_sync: RTL

- SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) that runs entirely in the system clock domain.
- It oversamples ss, sck and mosi through synchronizers and is the clocked peer for SPI_MASTER.
- It gives the host a valid/ready transmit buffer (one entry) and a received-word strobe, so user logic never runs on sck.
- Requires fclk >= 8 × fsck.

---
 rtl/spi_slave_sync.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: mode-0 SPI slave oversampled in the clk domain with a one-entry tx buffer
module spi_slave_sync #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ss,
  input  logic            sck,
  input  logic            mosi,
  output logic            miso,
  input  logic [size-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [size-1:0] rx_data,
  output logic            rx_valid,
  output logic            tx_underrun,
  output logic            busy
);
  localparam int cw = $clog2(size);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  logic ss_m_q, ss_s_q, ss_d_q, sck_m_q, sck_s_q, sck_d_q, mosi_m_q, mosi_s_q;
  logic sck_rise, sck_fall, ss_fall, ss_rise, load, bypass, accept;
  logic [0:0] state_q, state_d;
  logic [cw-1:0] bit_cnt_q, bit_cnt_d;
  logic done_q, done_d, buf_full_q, buf_full_d;
  logic miso_q, miso_d, rx_valid_q, rx_valid_d, tx_underrun_q, tx_underrun_d;
  logic [size-1:0] shift_tx_q, shift_tx_d, shift_rx_q, shift_rx_d;
  logic [size-1:0] buf_q, buf_d, rx_data_q, rx_data_d;
  assign sck_rise = sck_s_q & ~sck_d_q;
  assign sck_fall = ~sck_s_q & sck_d_q;
  assign ss_fall = ss_d_q & ~ss_s_q;
  assign ss_rise = ~ss_d_q & ss_s_q;
  // two-flop synchronizers plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {ss_m_q, ss_s_q, ss_d_q} <= '0;
      {sck_m_q, sck_s_q, sck_d_q} <= '0;
      {mosi_m_q, mosi_s_q} <= '0;
    end else begin
      {ss_m_q, ss_s_q, ss_d_q} <= {ss, ss_m_q, ss_s_q};
      {sck_m_q, sck_s_q, sck_d_q} <= {sck, sck_m_q, sck_s_q};
      {mosi_m_q, mosi_s_q} <= {mosi, mosi_m_q};
    end
  end
  // transfer FSM, shift registers, word load and transmit buffer next-state
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    done_d = done_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    load = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        load = 1'b1;
        bit_cnt_d = '0;
        done_d = 1'b0;
        state_d = ACTIVE;
      end
    end else if (ss_rise) begin
      state_d = IDLE;
      bit_cnt_d = '0;
      done_d = 1'b0;
    end else begin
      if (sck_rise) begin
        shift_rx_d = {shift_rx_q[size-2:0], mosi_s_q};
        if (bit_cnt_q == cw'(size - 1)) begin
          rx_data_d = shift_rx_d;
          rx_valid_d = 1'b1;
          bit_cnt_d = '0;
          done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      if (sck_fall) begin
        if (done_q) begin
          load = 1'b1;
          done_d = 1'b0;
        end else begin
          shift_tx_d = shift_tx_q << 1;
        end
      end
    end
    bypass = load & ~buf_full_q & tx_valid;
    if (load) shift_tx_d = buf_full_q ? buf_q : (tx_valid ? tx_data : '0);
    tx_underrun_d = load & ~buf_full_q & ~tx_valid;
    accept = tx_valid & ~buf_full_q & ~bypass;
    buf_full_d = accept | (buf_full_q & ~load);
    buf_d = accept ? tx_data : buf_q;
    miso_d = shift_tx_q[size-1];
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      done_q <= 1'b0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      tx_underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_q <= '0;
      miso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      done_q <= done_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      buf_full_q <= buf_full_d;
      buf_q <= buf_d;
      miso_q <= miso_d;
    end
  end
  assign miso = miso_q;
  assign tx_ready = ~buf_full_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign busy = (state_q == ACTIVE);
endmodule
